// File: rtl/scan_pkg.sv
// Shared constants for the multiplexed display scan bus: monitor states, error causes and
// the character codes used by the display driver.
package scan_pkg;

  localparam logic [2:0] StHunt = 3'd0;
  localparam logic [2:0] StOn3  = 3'd1;
  localparam logic [2:0] StGap3 = 3'd2;
  localparam logic [2:0] StOn2  = 3'd3;
  localparam logic [2:0] StGap2 = 3'd4;
  localparam logic [2:0] StOn1  = 3'd5;
  localparam logic [2:0] StGap1 = 3'd6;
  localparam logic [2:0] StOn0  = 3'd7;

  localparam logic [1:0] ERR_MULTI = 2'd0;
  localparam logic [1:0] ERR_ORDER = 2'd1;
  localparam logic [1:0] ERR_CHAR  = 2'd2;
  localparam logic [1:0] ERR_GAP   = 2'd3;

  localparam logic [3:0] CHAR_0 = 4'h0;
  localparam logic [3:0] CHAR_1 = 4'h1;
  localparam logic [3:0] CHAR_2 = 4'h2;
  localparam logic [3:0] CHAR_3 = 4'h3;
  localparam logic [3:0] CHAR_4 = 4'h4;
  localparam logic [3:0] CHAR_5 = 4'h5;
  localparam logic [3:0] CHAR_6 = 4'h6;
  localparam logic [3:0] CHAR_7 = 4'h7;
  localparam logic [3:0] CHAR_8 = 4'h8;
  localparam logic [3:0] CHAR_9 = 4'h9;
  localparam logic [3:0] CHAR_A = 4'hA;
  localparam logic [3:0] CHAR_B = 4'hB;
  localparam logic [3:0] CHAR_C = 4'hC;
  localparam logic [3:0] CHAR_D = 4'hD;
  localparam logic [3:0] CHAR_E = 4'hE;
  localparam logic [3:0] CHAR_F = 4'hF;

  // Digit position an ON/GAP state refers to; HUNT maps to 0 and is never consulted.
  function automatic logic [1:0] state_digit(input logic [2:0] st);
    case (st)
      StOn3, StGap3: return 2'd3;
      StOn2, StGap2: return 2'd2;
      StOn1, StGap1: return 2'd1;
      default:       return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/gap_timer.sv
// Saturating count of consecutive blank cycles between two digits of a frame, with a flag that
// says the next blank cycle brings the count to GAP_MAX.
module gap_timer #(
  parameter int unsigned GAP_MAX = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic inc_i,
  output logic hit_o
);

  localparam int unsigned CntW = $clog2(GAP_MAX + 1);

  logic [CntW-1:0] cnt_q;

  assign hit_o = (cnt_q == CntW'(GAP_MAX - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != CntW'(GAP_MAX))) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/scan_capture.sv
// Receive-side checker for the 4-digit multiplexed display scan bus; emits one 16-bit frame per
// clean an3..an0 scan. Define SCAN_CAPTURE_TIMEOUT_EN to bound blank gaps inside a frame.
module scan_capture
  import scan_pkg::*;
#(
  parameter int unsigned GAP_MAX = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        an3,
  input  logic        an2,
  input  logic        an1,
  input  logic        an0,
  input  logic [3:0]  char,
  output logic [15:0] frame,
  output logic        frame_valid,
  output logic        err,
  output logic [1:0]  err_code,
  output logic        locked
);

  logic [3:0] lit;
  logic       blank, single, multi;
  logic [1:0] lit_idx;

  assign lit    = ~{an3, an2, an1, an0};
  assign blank  = (lit == 4'b0000);
  assign single = !blank && ((lit & (lit - 4'd1)) == 4'b0000);
  assign multi  = !blank && !single;

  always_comb begin
    lit_idx = 2'd0;
    case (lit)
      4'b1000: lit_idx = 2'd3;
      4'b0100: lit_idx = 2'd2;
      4'b0010: lit_idx = 2'd1;
      default: lit_idx = 2'd0;
    endcase
  end

  logic [2:0]      state_q, state_d;
  logic [3:0][3:0] shadow_q, shadow_d;
  logic            prev_blank_q;
  logic [1:0]      digit, next_digit;
  logic            commit, err_set;
  logic [1:0]      err_sel;

`ifdef SCAN_CAPTURE_TIMEOUT_EN
  logic gap_clr, gap_inc, gap_hit;

  gap_timer #(
    .GAP_MAX(GAP_MAX)
  ) u_gap_timer (
    .clk    (clk),
    .reset  (reset),
    .clear_i(gap_clr),
    .inc_i  (gap_inc),
    .hit_o  (gap_hit)
  );
`else
  logic unused_gap_max;
  assign unused_gap_max = ^GAP_MAX;
`endif

  always_comb begin
    digit      = state_digit(state_q);
    next_digit = digit - 2'd1;
    state_d    = state_q;
    shadow_d   = shadow_q;
    commit     = 1'b0;
    err_set    = 1'b0;
    err_sel    = ERR_MULTI;
`ifdef SCAN_CAPTURE_TIMEOUT_EN
    gap_clr    = 1'b0;
    gap_inc    = 1'b0;
`endif
    case (state_q)
      StHunt: begin
        // Only a fresh blank->an3 edge starts a frame; anything else is silently skipped.
        if (single && (lit_idx == 2'd3) && prev_blank_q) begin
          state_d     = StOn3;
          shadow_d[3] = char;
        end
      end
      StOn3, StOn2, StOn1, StOn0: begin
        if (multi) begin
          err_set = 1'b1;
          err_sel = ERR_MULTI;
        end else if (single && (lit_idx != digit)) begin
          err_set = 1'b1;
          err_sel = ERR_ORDER;
        end else if (single && (char != shadow_q[digit])) begin
          err_set = 1'b1;
          err_sel = ERR_CHAR;
        end else if (blank) begin
          if (state_q == StOn0) begin
            commit  = 1'b1;
            state_d = StHunt;
          end else begin
            state_d = state_q + 3'd1;
`ifdef SCAN_CAPTURE_TIMEOUT_EN
            gap_clr = 1'b1;
`endif
          end
        end
      end
      StGap3, StGap2, StGap1: begin
        if (multi) begin
          err_set = 1'b1;
          err_sel = ERR_MULTI;
        end else if (single && (lit_idx != next_digit)) begin
          err_set = 1'b1;
          err_sel = ERR_ORDER;
        end else if (single) begin
          state_d              = state_q + 3'd1;
          shadow_d[next_digit] = char;
        end
`ifdef SCAN_CAPTURE_TIMEOUT_EN
        else begin
          gap_inc = 1'b1;
          if (gap_hit) begin
            err_set = 1'b1;
            err_sel = ERR_GAP;
          end
        end
`endif
      end
      default: state_d = StHunt;
    endcase
    if (err_set) state_d = StHunt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StHunt;
      shadow_q     <= '0;
      prev_blank_q <= 1'b0;
      frame        <= 16'h0000;
      frame_valid  <= 1'b0;
      err          <= 1'b0;
      err_code     <= 2'b00;
      locked       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shadow_q     <= shadow_d;
      prev_blank_q <= blank;
      frame_valid  <= commit;
      err          <= err_set;
      if (commit) frame <= shadow_q;
      if (err_set) err_code <= err_sel;
      if (err_set) begin
        locked <= 1'b0;
      end else if (commit) begin
        locked <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_scan_capture.sv
// Self-checking bench for scan_capture: scenario table, hand-written corner sequences and
// randomized scans, all compared cycle by cycle against a digit-counting reference model.
module tb_scan_capture;

  localparam int unsigned GapMax = 8;
`ifdef SCAN_CAPTURE_TIMEOUT_EN
  localparam bit TimeoutEn = 1'b1;
`else
  localparam bit TimeoutEn = 1'b0;
`endif
  localparam logic [3:0] Blank = 4'b1111;
  localparam int FNone = 0, FMulti = 1, FSkip = 2, FNoBlank = 3, FChar = 4, FGap = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic        an3, an2, an1, an0;
  logic [3:0]  char;
  logic [15:0] frame;
  logic        frame_valid, err, locked;
  logic [1:0]  err_code;

  always #5 clk = ~clk;

  scan_capture #(
    .GAP_MAX(GapMax)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .an3        (an3),
    .an2        (an2),
    .an1        (an1),
    .an0        (an0),
    .char       (char),
    .frame      (frame),
    .frame_valid(frame_valid),
    .err        (err),
    .err_code   (err_code),
    .locked     (locked)
  );

  int checks = 0;
  int errors = 0;
  int seen_err, seen_fv;

  // Reference model: number of digits taken so far in the current frame (0 = hunting).
  int          m_got, m_gap;
  bit          m_lit, m_prev_blank;
  logic [3:0]  m_dig[4];
  logic [15:0] m_frame;
  bit          m_fv, m_err, m_locked;
  logic [1:0]  m_code;

  typedef struct {
    logic [15:0] val;
    int          fault;
    int          errs;
    logic [1:0]  code;
    logic [15:0] frame;
    int          fvs;
    bit          locked;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  function automatic logic [3:0] one_low(input int k);
    logic [3:0] v;
    v    = 4'b1111;
    v[k] = 1'b0;
    return v;
  endfunction

  task automatic model_reset();
    m_got = 0; m_gap = 0; m_lit = 0; m_prev_blank = 0;
    m_frame = '0; m_fv = 0; m_err = 0; m_code = '0; m_locked = 0;
    for (int i = 0; i < 4; i++) m_dig[i] = '0;
  endtask

  task automatic raise(input logic [1:0] code);
    m_err = 1; m_code = code; m_locked = 0; m_got = 0;
  endtask

  task automatic model_step(input logic [3:0] an_v, input logic [3:0] ch);
    int n_low, idx, want;
    n_low = $countones(~an_v);
    idx   = 0;
    for (int i = 0; i < 4; i++) if (!an_v[i]) idx = i;
    m_fv  = 0;
    m_err = 0;
    if (m_got == 0) begin
      if (n_low == 1 && idx == 3 && m_prev_blank) begin
        m_got = 1; m_lit = 1; m_dig[3] = ch;
      end
    end else if (m_lit) begin
      want = 4 - m_got;
      if (n_low > 1) raise(2'd0);
      else if (n_low == 1 && idx != want) raise(2'd1);
      else if (n_low == 1 && ch != m_dig[want]) raise(2'd2);
      else if (n_low == 0) begin
        if (m_got == 4) begin
          m_frame = {m_dig[3], m_dig[2], m_dig[1], m_dig[0]};
          m_fv = 1; m_locked = 1; m_got = 0;
        end else begin
          m_lit = 0; m_gap = 0;
        end
      end
    end else begin
      want = 3 - m_got;
      if (n_low > 1) raise(2'd0);
      else if (n_low == 1 && idx != want) raise(2'd1);
      else if (n_low == 1) begin
        m_dig[want] = ch; m_got++; m_lit = 1;
      end else begin
        m_gap++;
        if (TimeoutEn && m_gap >= GapMax) raise(2'd3);
      end
    end
    m_prev_blank = (n_low == 0);
  endtask

  task automatic cyc(input logic [3:0] an_v, input logic [3:0] ch);
    {an3, an2, an1, an0} = an_v;
    char = ch;
    @(posedge clk);
    model_step(an_v, ch);
    #1;
    check("cycle", {frame, frame_valid, err, err_code, locked},
          {m_frame, m_fv, m_err, m_code, m_locked});
    if (err) seen_err++;
    if (frame_valid) seen_fv++;
  endtask

  task automatic play_scan(input logic [15:0] v, input int fault);
    for (int k = 3; k >= 0; k--) begin
      logic [3:0] c;
      int trail;
      c     = v[4*k +: 4];
      trail = 2;
      if (fault == FSkip && k == 2) continue;
      if (!(fault == FNoBlank && k == 2)) cyc(Blank, 4'($urandom));
      cyc(one_low(k), c);
      if (fault == FChar && k == 2) cyc(one_low(k), c ^ 4'h7);
      if (k == 3) begin
        if (fault == FNoBlank) trail = 0;
        if (fault == FGap) trail = 8;
        if (fault == FMulti) begin
          cyc(Blank, 4'h0);
          cyc(4'b1001, 4'h0);
          trail = 1;
        end
      end
      repeat (trail) cyc(Blank, 4'($urandom));
    end
  endtask

  task automatic random_scan();
    for (int k = 3; k >= 0; k--) begin
      int nb;
      logic [3:0] c;
      nb = ($urandom_range(0, 9) == 0) ? $urandom_range(8, 10) : $urandom_range(1, 3);
      c  = 4'($urandom);
      repeat (nb) cyc(Blank, 4'($urandom));
      repeat ($urandom_range(1, 3)) begin
        if ($urandom_range(0, 19) == 0) cyc(4'($urandom), 4'($urandom));
        else if ($urandom_range(0, 29) == 0) cyc(one_low(k), c ^ 4'h1);
        else cyc(one_low(k), c);
      end
    end
    cyc(Blank, 4'h0);
  endtask

  initial begin
    vecs[0] = '{16'h3246, FNone,    0, 2'd0, 16'h3246, 1, 1'b1};
    vecs[1] = '{16'h3246, FNone,    0, 2'd0, 16'h3246, 1, 1'b1};
    vecs[2] = '{16'h1111, FMulti,   1, 2'd0, 16'h3246, 0, 1'b0};
    vecs[3] = '{16'h3246, FNone,    0, 2'd0, 16'h3246, 1, 1'b1};
    vecs[4] = '{16'hABCD, FSkip,    1, 2'd1, 16'h3246, 0, 1'b0};
    vecs[5] = '{16'h7777, FNoBlank, 1, 2'd1, 16'h3246, 0, 1'b0};
    vecs[6] = '{16'h9218, FChar,    1, 2'd2, 16'h3246, 0, 1'b0};
    vecs[7] = '{16'h5A5A, FNone,    0, 2'd2, 16'h5A5A, 1, 1'b1};
`ifdef SCAN_CAPTURE_TIMEOUT_EN
    vecs[8] = '{16'h1234, FGap,     1, 2'd3, 16'h5A5A, 0, 1'b0};
    vecs[9] = '{16'h0F0F, FNone,    0, 2'd3, 16'h0F0F, 1, 1'b1};
`else
    vecs[8] = '{16'h1234, FGap,     0, 2'd2, 16'h1234, 1, 1'b1};
    vecs[9] = '{16'h0F0F, FNone,    0, 2'd2, 16'h0F0F, 1, 1'b1};
`endif

    reset = 1'b0;
    {an3, an2, an1, an0} = Blank;
    char = 4'h0;
    model_reset();
    #2;
    check("reset outputs", {frame, frame_valid, err, err_code, locked}, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    foreach (vecs[i]) begin
      seen_err = 0;
      seen_fv  = 0;
      play_scan(vecs[i].val, vecs[i].fault);
      check($sformatf("row%0d errs", i), seen_err, vecs[i].errs);
      check($sformatf("row%0d code", i), err_code, vecs[i].code);
      check($sformatf("row%0d frame", i), frame, vecs[i].frame);
      check($sformatf("row%0d fvs", i), seen_fv, vecs[i].fvs);
      check($sformatf("row%0d locked", i), locked, vecs[i].locked);
    end

    // Error while an3 is lit: the held an3 must not restart capture without a blank first.
    seen_err = 0;
    seen_fv  = 0;
    cyc(Blank, 4'h0);
    cyc(one_low(3), 4'h1);
    cyc(one_low(3), 4'h2);
    repeat (2) cyc(one_low(3), 4'h2);
    for (int k = 2; k >= 0; k--) begin
      cyc(Blank, 4'h0);
      cyc(one_low(k), 4'h5);
    end
    cyc(Blank, 4'h0);
    check("held an3 errs", seen_err, 1);
    check("held an3 fvs", seen_fv, 0);
    check("held an3 frame", frame, 16'h0F0F);

    // Exactly GapMax blanks between digits and a long on-time are both legal.
    seen_err = 0;
    seen_fv  = 0;
    cyc(Blank, 4'h0);
    cyc(one_low(3), 4'h8);
    repeat (GapMax) cyc(Blank, 4'h0);
    repeat (20) cyc(one_low(2), 4'h4);
    cyc(Blank, 4'h0);
    cyc(one_low(1), 4'h2);
    cyc(Blank, 4'h0);
    cyc(one_low(0), 4'h1);
    cyc(Blank, 4'h0);
    check("max gap errs", seen_err, 0);
    check("max gap frame", frame, 16'h8421);
    check("max gap locked", locked, 1);

    // Asynchronous reset while an1 is lit.
    cyc(Blank, 4'h0);
    cyc(one_low(3), 4'h4);
    cyc(Blank, 4'h0);
    cyc(one_low(2), 4'h3);
    cyc(Blank, 4'h0);
    cyc(one_low(1), 4'h2);
    #3;
    reset = 1'b0;
    #1;
    check("async reset", {frame, frame_valid, err, err_code, locked}, 32'h0);
    model_reset();
    @(negedge clk);
    reset    = 1'b1;
    seen_fv  = 0;
    play_scan(16'h6789, FNone);
    check("post reset frame", frame, 16'h6789);
    check("post reset fvs", seen_fv, 1);

    for (int n = 0; n < 200; n++) random_scan();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/scan_capture.md
# scan_capture

Receive-side monitor for the 4-digit multiplexed display scan bus (active-low anodes an3..an0 plus 4-bit char). It follows the scan order an3→an2→an1→an0, captures the character shown under each anode, and checks protocol rules. After each complete, error-free scan it presents the four digits as one 16-bit frame. It sits beside the display counter/driver as an on-chip checker, and is the bench reference for any scan generator.

## Interface
Parameters:
- GAP_MAX, default 8: maximum consecutive all-blank cycles allowed between two digits inside a frame. Must be ≥1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low; clears all state and outputs immediately.
- an3, an2, an1, an0  in  1 each  scan anodes, active-low; synchronous to clk.
- char  in  4  digit code shown under the currently low anode.
- frame  out  16  last good frame {d3,d2,d1,d0}; reset 16'h0000.
- frame_valid  out  1  one-cycle pulse when frame updates; reset 0.
- err  out  1  one-cycle pulse on protocol violation; reset 0.
- err_code  out  2  cause of the last error, held until the next error; reset 2'b00. Codes: 0 multi-anode, 1 order, 2 char-change, 3 gap timeout.
- locked  out  1  high from the first frame_valid until the next err; reset 0.

## Operation
Anode classes, evaluated each cycle:
- BLANK: all four anodes high.
- SINGLE(k): exactly one anode, ank, low.
- MULTI: two or more anodes low.

FSM states: HUNT, ON3, GAP3, ON2, GAP2, ON1, GAP1, ON0. Reset state is HUNT.

- HUNT
  - SINGLE(3) with previous cycle BLANK → ON3; capture char into d3 shadow.
  - Everything else is ignored, including MULTI, and no error is raised.
- ONk
  - SINGLE(k) with unchanged char → stay.
  - Char differs from captured value → error 2.
  - BLANK → GAPk (k>0), clearing the gap counter. For k=0: commit d3..d0 to frame and go to HUNT.
  - SINGLE(j≠k) → error 1. A blank cycle between digits is mandatory.
  - MULTI → error 0.
- GAPk
  - BLANK → increment gap counter.
  - SINGLE(k-1) → ON(k-1); capture char.
  - SINGLE(other) → error 1.
  - MULTI → error 0.
  - Gap counter reaching GAP_MAX while still BLANK → error 3.
- Error priority when several conditions hold: 0 > 1 > 2 > 3.
- Error action:
  - err pulses; err_code is loaded; locked clears; state goes to HUNT.
  - Shadow digits are discarded and frame is unchanged.
- Frame commit:
  - Atomic: all 16 bits update in the same cycle.
  - Partial frames never reach frame.
- The gap after an0 (HUNT) is unbounded.
- Gap counter width is $clog2(GAP_MAX+1). It saturates and never wraps.

## Timing
- All outputs are registered.
- frame and frame_valid update on the clock edge following the first cycle an0 is sampled high after ON0, i.e. one cycle of latency after release.
- err and err_code update on the edge following the violating sample.
- HUNT requires a blank→an3 edge. After an error, if an3 is still low, capture waits for the next full blank→an3 transition.
- Any anode may stay low any number of cycles (no on-time limit).
- Asserting reset mid-frame drops all outputs to their reset values asynchronously. The first frame after release needs a full an3..an0 scan.

## Configuration
- SCAN_CAPTURE_TIMEOUT_EN defined: gap counter and error 3 are present, as above.
- SCAN_CAPTURE_TIMEOUT_EN undefined:
  - Gap counter and GAP_MAX checking are removed.
  - Blank gaps inside a frame are unbounded.
  - err_code 3 is never produced.

## Structure
- Package scan_pkg holds:
  - State enumeration.
  - Error code constants: ERR_MULTI, ERR_ORDER, ERR_CHAR, ERR_GAP.
  - Character code constants 4'h0..4'hF shared with the display driver.
- Sub-module gap_timer contains the saturating blank-cycle counter with clear/enable and a reached-GAP_MAX flag. Its instance is wrapped by SCAN_CAPTURE_TIMEOUT_EN.
- The anode classifier (BLANK/SINGLE/MULTI) stays inline.

## Test plan
- **Nominal scan:** repeating 16-cycle scan (blank, an3 low char 3, blank ×2, blank, an2 low char 2, blank ×2, …, an0 low char 6, blank) → frame=16'h3246, frame_valid once per 16 cycles, locked=1 after the first frame, err never asserted.
- **Multi-anode:** an2 and an1 low together during GAP3 → err pulse, err_code=0, frame holds its previous value, locked=0, next clean scan recovers.
- **Skipped digit:** an3 then an1 (an2 skipped) → err_code=1. Also an3 low followed directly by an2 low with no blank → err_code=1.
- **Char change:** char changes 2→5 while an2 is held low → err_code=2, frame unchanged.
- **Gap timeout (GAP_MAX=8):** 9 blank cycles after an3 → err_code=3 when the macro is defined. Without the macro the same stimulus yields no error and the frame is captured.
- **Reset mid-frame:** reset pulsed low during ON1 → frame=0, locked=0, err=0 immediately; a complete scan after release gives frame_valid with the new value.
